// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
//
// True dual-port synchronous RAM. Two independent read/write ports (A and B)
// share one clock and one storage array. In the VGA design port A takes CPU
// character writes and port B is the continuous display-scan read port.
//
// Parameters
//   ADDR_WIDTH : address bits per port, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH : word width in bits
//   OUT_REG    : 0 = read data one clock after the read edge,
//                1 = extra output register, read data two clocks after
//
// Ports
//   clk                 : sole clock, everything happens on the rising edge
//   rst                 : synchronous active-high reset of the read path
//   address_a/b         : word address per port
//   wren_a/b            : write enable per port
//   data_a/b            : write data per port
//   rden_a/b            : read enable per port
//   q_a/q_b             : read data per port
//
// Optional feature macro
//   RAM_ZERO_INIT_EN    : when defined, every word of the array starts at
//                         zero. When undefined, the array has no initial
//                         value and pre-write reads are undefined.
// ---------------------------------------------------------------------------
module dual_port_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 56,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage array. The zero initialiser is a declaration initialiser so it
  // also lands in the FPGA bitstream, not only in simulation.
`ifdef RAM_ZERO_INIT_EN
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
`else
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`endif

  // First-stage read registers, one per port.
  logic [DATA_WIDTH-1:0] r_stage_a;
  logic [DATA_WIDTH-1:0] r_stage_b;

  // Both ports writing the same word on the same edge: port A wins.
  logic w_collide;
  assign w_collide = wren_a && wren_b && (address_a == address_b);

  // Array writes. Reset only suppresses writes, it never clears contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wren_a) begin
        r_mem[address_a] <= data_a;
      end
      if (wren_b && !w_collide) begin
        r_mem[address_b] <= data_b;
      end
    end
  end

  // First read stage. Non-blocking sampling of the array gives read-first
  // behaviour for both same-port and cross-port read-during-write: the old
  // word is captured while the new one is stored. rden low holds the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_a <= '0;
      r_stage_b <= '0;
    end else begin
      if (rden_a) begin
        r_stage_a <= r_mem[address_a];
      end
      if (rden_b) begin
        r_stage_b <= r_mem[address_b];
      end
    end
  end

  // Optional output register stage. It advances from the first stage on
  // every edge regardless of rden, so a held first stage simply re-flows.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_out_a;
      logic [DATA_WIDTH-1:0] r_out_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_a <= '0;
          r_out_b <= '0;
        end else begin
          r_out_a <= r_stage_a;
          r_out_b <= r_stage_b;
        end
      end

      assign q_a = r_out_a;
      assign q_b = r_out_b;
    end else begin : g_no_out_reg
      assign q_a = r_stage_a;
      assign q_b = r_stage_b;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram
//
// Self-checking bench for dual_port_ram with default parameters
// (2048 x 56, OUT_REG = 1). A word-level model of the memory and of the
// two-edge read latency predicts q_a/q_b; a compare process checks them on
// every falling edge. Directed scenarios pin the model with literal values,
// then a randomized phase exercises collisions, read-during-write and reset.
// ---------------------------------------------------------------------------
module tb_dual_port_ram;

  localparam int AW = 11;
  localparam int DW = 56;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b, rden_a, rden_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a, q_b;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  // Behavioural model: the memory contents, the most recent word returned
  // by a read on each port, and what each q must show after this edge.
  logic [DW-1:0] modelMem [2**AW];
  logic [DW-1:0] lastReadA, lastReadB;
  logic [DW-1:0] expQa, expQb;

  localparam logic [DW-1:0] VAL5 = 56'h00FF00ABCD0041;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a),
    .rden_a(rden_a), .q_a(q_a),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b),
    .rden_b(rden_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  // Model update for one rising edge, using the inputs driven for it.
  // With the output register, q after this edge shows whatever the port's
  // most recent read had returned as of the previous edge.
  task automatic modelEdge();
    if (rst) begin
      lastReadA = '0;
      lastReadB = '0;
      expQa     = '0;
      expQb     = '0;
    end else begin
      expQa = lastReadA;
      expQb = lastReadB;
      if (rden_a) lastReadA = modelMem[address_a];
      if (rden_b) lastReadB = modelMem[address_b];
      if (wren_b && !(wren_a && address_a == address_b))
        modelMem[address_b] = data_b;
      if (wren_a)
        modelMem[address_a] = data_a;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    rst = 1'b0;
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    data_a = '0; data_b = '0;
  endtask

  task automatic applyStimulus(input bit wa, input bit ra, input logic [AW-1:0] aa,
                               input logic [DW-1:0] da, input bit wb, input bit rb,
                               input logic [AW-1:0] ab, input logic [DW-1:0] db);
    wren_a = wa; rden_a = ra; address_a = aa; data_a = da;
    wren_b = wb; rden_b = rb; address_b = ab; data_b = db;
    cycle();
    idleInputs();
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
    end
  endtask

  // Continuous comparison of both read ports against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model q_a", q_a, expQa);
      checkOutput("model q_b", q_b, expQb);
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) modelMem[i] = '0;
    lastReadA = '0; lastReadB = '0; expQa = '0; expQb = '0;
    address_a = '0; address_b = '0;
    idleInputs();
    @(negedge clk);

    // Reset clears both outputs.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset q_a", q_a, '0);
    checkOutput("reset q_b", q_b, '0);

`ifdef RAM_ZERO_INIT_EN
    // Untouched word reads as zero.
    applyStimulus(0, 1, 11'd2047, '0, 0, 1, 11'd2047, '0);
    cycle();
    checkOutput("zero init q_a", q_a, '0);
    checkOutput("zero init q_b", q_b, '0);
`endif

    // Write on A, read on B, data two edges after the read edge.
    applyStimulus(1, 0, 11'd5, VAL5, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 0, 1, 11'd5, '0);
    cycle();
    checkOutput("cross read q_b", q_b, VAL5);
    checkOutput("cross read q_a", q_a, '0);

    // Read-first on the same port.
    applyStimulus(1, 0, 11'd7, 56'd1, 0, 0, '0, '0);
    applyStimulus(1, 1, 11'd7, 56'd2, 0, 0, '0, '0);
    cycle();
    checkOutput("read-first old", q_a, 56'd1);
    applyStimulus(0, 1, 11'd7, '0, 0, 0, '0, '0);
    cycle();
    checkOutput("read-first new", q_a, 56'd2);

    // Write collision: port A wins.
    applyStimulus(1, 0, 11'd12, 56'd3, 1, 0, 11'd12, 56'd9);
    applyStimulus(0, 1, 11'd12, '0, 0, 1, 11'd12, '0);
    cycle();
    checkOutput("collision q_a", q_a, 56'd3);
    checkOutput("collision q_b", q_b, 56'd3);

    // rden low holds the previous read.
    applyStimulus(0, 0, '0, '0, 0, 1, 11'd5, '0);
    cycle();
    applyStimulus(0, 0, '0, '0, 0, 0, 11'd6, '0);
    cycle();
    checkOutput("rden hold q_b", q_b, VAL5);

    // Reset ignores writes and keeps array contents.
    applyStimulus(1, 0, 11'd20, 56'h1234, 1, 0, 11'd30, ONES);
    applyStimulus(0, 0, '0, '0, 0, 1, 11'd30, '0);
    cycle();
    checkOutput("pre-reset q_b", q_b, ONES);
    rst = 1'b1;
    applyStimulus(1, 0, 11'd20, 56'd1, 0, 0, '0, '0);
    checkOutput("post-reset q_a", q_a, '0);
    checkOutput("post-reset q_b", q_b, '0);
    applyStimulus(0, 1, 11'd20, '0, 0, 1, 11'd5, '0);
    cycle();
    checkOutput("mem20 kept", q_a, 56'h1234);
    checkOutput("mem5 kept", q_b, VAL5);

    // Preload a small window so random reads always hit written words.
    for (int i = 0; i < 32; i++)
      applyStimulus(1, 0, i[AW-1:0], {$urandom, $urandom}, 0, 0, '0, '0);

    // Randomized traffic over the 32-word window for plenty of collisions.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      wren_a = $urandom_range(0, 1);
      rden_a = $urandom_range(0, 1);
      wren_b = $urandom_range(0, 1);
      rden_b = $urandom_range(0, 1);
      address_a = AW'($urandom_range(0, 31));
      address_b = AW'($urandom_range(0, 31));
      data_a = {$urandom, $urandom};
      data_b = {$urandom, $urandom};
      cycle();
    end
    idleInputs();
    cycle();
    cycle();

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
